wdt_window_ctrl: RTL and testbench

//  Windowed watchdog controller: holds timeout/window config, prescales clk into ticks,
//  and sequences IDLE->RUN->WARN->BITE. Kicks must land inside the open window.

---
 rtl/wdt_window_ctrl.sv | 169 ++++++++++++++++
 tb/tb_wdt_window_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/wdt_window_ctrl.sv
// Windowed watchdog: prescaled tick counter with an early-kick window, warning
// phase with grace period, and a latched reset request until enable drops.
module wdt_window_ctrl #(
  parameter int CNT_W    = 16,
  parameter int PRESCALE = 4,
  parameter int GRACE    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_timeout,
  input  logic [CNT_W-1:0] cfg_window,
  output logic             cfg_err,
  input  logic             enable,
  input  logic             kick,
  output logic [CNT_W-1:0] count_o,
  output logic [1:0]       state_o,
  output logic             early_irq,
  output logic             warn_irq,
  output logic             wdt_reset
);

  localparam int PS_W = $clog2(PRESCALE) + 1;
  localparam int GR_W = $clog2(GRACE) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_WARN = 2'b10,
    S_BITE = 2'b11
  } state_t;

  state_t           r_state,    w_stateNext;
  logic [CNT_W-1:0] r_count,    w_countNext;
  logic [PS_W-1:0]  r_presc,    w_prescNext;
  logic [GR_W-1:0]  r_grace,    w_graceNext;
  logic [CNT_W-1:0] r_timeout,  w_timeoutNext;
  logic [CNT_W-1:0] r_window,   w_windowNext;
  logic             r_cfgErr,   w_cfgErrNext;
  logic             r_earlyIrq, w_earlyIrqNext;
  logic             w_tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_presc    <= '0;
      r_grace    <= '0;
      r_timeout  <= '1;
      r_window   <= '0;
      r_cfgErr   <= 1'b0;
      r_earlyIrq <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_count    <= w_countNext;
      r_presc    <= w_prescNext;
      r_grace    <= w_graceNext;
      r_timeout  <= w_timeoutNext;
      r_window   <= w_windowNext;
      r_cfgErr   <= w_cfgErrNext;
      r_earlyIrq <= w_earlyIrqNext;
    end
  end

  // Ticks only exist while the watchdog is counting; the prescaler restarts
  // on every kick and every state change so tick phase is relative to them.
  assign w_tick = ((r_state == S_RUN) || (r_state == S_WARN)) &&
                  (r_presc == PS_W'(PRESCALE - 1));

  always_comb begin
    w_stateNext    = r_state;
    w_countNext    = r_count;
    w_prescNext    = r_presc;
    w_graceNext    = r_grace;
    w_timeoutNext  = r_timeout;
    w_windowNext   = r_window;
    w_cfgErrNext   = 1'b0;
    w_earlyIrqNext = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (cfg_valid) begin
          if ((cfg_timeout != '0) && (cfg_window < cfg_timeout)) begin
            w_timeoutNext = cfg_timeout;
            w_windowNext  = cfg_window;
          end else begin
            w_cfgErrNext = 1'b1;
          end
        end
        w_countNext = '0;
        w_prescNext = '0;
        w_graceNext = '0;
        if (enable) w_stateNext = S_RUN;
      end

      S_RUN: begin
        if (!enable) begin
          w_stateNext = S_IDLE;
          w_countNext = '0;
          w_prescNext = '0;
          w_graceNext = '0;
        end else if (kick) begin
          w_prescNext = '0;
          if (r_count >= r_window) begin
            w_countNext = '0;
          end else begin
            w_stateNext    = S_BITE;
            w_earlyIrqNext = 1'b1;
          end
        end else if (w_tick) begin
          w_prescNext = '0;
          w_countNext = r_count + CNT_W'(1);
          if (r_count == (r_timeout - CNT_W'(1))) begin
            w_stateNext = S_WARN;
            w_graceNext = '0;
          end
        end else begin
          w_prescNext = r_presc + PS_W'(1);
        end
      end

      S_WARN: begin
        if (!enable) begin
          w_stateNext = S_IDLE;
          w_countNext = '0;
          w_prescNext = '0;
          w_graceNext = '0;
        end else if (kick) begin
          w_stateNext = S_RUN;
          w_countNext = '0;
          w_prescNext = '0;
          w_graceNext = '0;
        end else if (w_tick) begin
          w_prescNext = '0;
          if (r_grace == GR_W'(GRACE - 1)) begin
            w_stateNext = S_BITE;
          end else begin
            w_graceNext = r_grace + GR_W'(1);
          end
        end else begin
          w_prescNext = r_presc + PS_W'(1);
        end
      end

      S_BITE: begin
        w_prescNext = '0;
        if (!enable) begin
          w_stateNext = S_IDLE;
          w_countNext = '0;
          w_graceNext = '0;
        end
      end

      default: begin
        w_stateNext = S_IDLE;
      end
    endcase
  end

  assign cfg_ready = (r_state == S_IDLE);
  assign cfg_err   = r_cfgErr;
  assign early_irq = r_earlyIrq;
  assign warn_irq  = (r_state == S_WARN);
  assign wdt_reset = (r_state == S_BITE);
  assign count_o   = r_count;
  assign state_o   = r_state;

endmodule

// File: tb/tb_wdt_window_ctrl.sv
// Scoreboard bench for wdt_window_ctrl: stimulus queues cycle-stamped expected
// snapshots, a negedge monitor matches them against the DUT outputs.
module tb_wdt_window_ctrl;

  localparam int CNT_W = 16;
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_WARN = 2'b10;
  localparam logic [1:0] ST_BITE = 2'b11;

  logic             clk;
  logic             rst;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_timeout;
  logic [CNT_W-1:0] cfg_window;
  logic             cfg_err;
  logic             enable;
  logic             kick;
  logic [CNT_W-1:0] count_o;
  logic [1:0]       state_o;
  logic             early_irq;
  logic             warn_irq;
  logic             wdt_reset;

  typedef struct {
    int               cyc;
    string            name;
    logic [1:0]       st;
    logic [CNT_W-1:0] cnt;
    logic             warn;
    logic             bite;
    logic             early;
    logic             err;
    logic             rdy;
  } expect_t;

  expect_t sbQueue[$];
  int      cyc = 0;
  int      cmpCount = 0;
  int      errCount = 0;

  wdt_window_ctrl #(.CNT_W(CNT_W), .PRESCALE(4), .GRACE(8)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_timeout(cfg_timeout), .cfg_window(cfg_window), .cfg_err(cfg_err),
    .enable(enable), .kick(kick),
    .count_o(count_o), .state_o(state_o),
    .early_irq(early_irq), .warn_irq(warn_irq), .wdt_reset(wdt_reset)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic expectAt(input int c, input string name, input logic [1:0] st,
                          input int cnt, input logic warn, input logic bite,
                          input logic early, input logic err, input logic rdy);
    expect_t e;
    e.cyc = c; e.name = name; e.st = st; e.cnt = CNT_W'(cnt);
    e.warn = warn; e.bite = bite; e.early = early; e.err = err; e.rdy = rdy;
    sbQueue.push_back(e);
  endtask

  task automatic checkOutput(input expect_t e);
    cmpCount++;
    if (state_o !== e.st || count_o !== e.cnt || warn_irq !== e.warn ||
        wdt_reset !== e.bite || early_irq !== e.early || cfg_err !== e.err ||
        cfg_ready !== e.rdy) begin
      errCount++;
      $display("[TB] FAIL %s @cyc %0d: got st=%b cnt=%0d warn=%b rst=%b early=%b err=%b rdy=%b, want st=%b cnt=%0d warn=%b rst=%b early=%b err=%b rdy=%b",
               e.name, cyc, state_o, count_o, warn_irq, wdt_reset, early_irq, cfg_err, cfg_ready,
               e.st, e.cnt, e.warn, e.bite, e.early, e.err, e.rdy);
    end
  endtask

  // Monitor: retire every expectation stamped with the current cycle.
  always @(negedge clk) begin
    int i;
    i = 0;
    while (i < sbQueue.size()) begin
      if (sbQueue[i].cyc == cyc) begin
        checkOutput(sbQueue[i]);
        sbQueue.delete(i);
      end else if (sbQueue[i].cyc < cyc) begin
        cmpCount++;
        errCount++;
        $display("[TB] FAIL %s: expectation for cyc %0d never checked (now %0d)",
                 sbQueue[i].name, sbQueue[i].cyc, cyc);
        sbQueue.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic stepTo(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input int to, input int win, input logic expErr, input string name);
    int c0;
    c0 = cyc;
    cfg_valid   = 1'b1;
    cfg_timeout = CNT_W'(to);
    cfg_window  = CNT_W'(win);
    expectAt(c0 + 1, {name, "_pulse"}, ST_IDLE, 0, 0, 0, 0, expErr, 1);
    expectAt(c0 + 2, {name, "_after"}, ST_IDLE, 0, 0, 0, 0, 0, 1);
    stepTo(c0 + 1);
    cfg_valid = 1'b0;
    stepTo(c0 + 2);
  endtask

  initial begin
    int e, f, g, h;
    rst = 1'b1; cfg_valid = 1'b0; cfg_timeout = '0; cfg_window = '0;
    enable = 1'b0; kick = 1'b0;
    expectAt(1, "reset_state", ST_IDLE, 0, 0, 0, 0, 0, 1);
    stepTo(3);
    rst = 1'b0;

    applyStimulus(10, 3, 1'b0, "cfg_ok");
    applyStimulus(10, 12, 1'b1, "cfg_win_ge_to");
    applyStimulus(0, 0, 1'b1, "cfg_to_zero");

    // No kick: RUN, WARN after 10 ticks, BITE after 8 grace ticks.
    e = cyc;
    enable = 1'b1;
    expectAt(e + 1,  "run_entry",     ST_RUN,  0,  0, 0, 0, 0, 0);
    expectAt(e + 4,  "first_tick_pre", ST_RUN, 0,  0, 0, 0, 0, 0);
    expectAt(e + 5,  "first_tick",    ST_RUN,  1,  0, 0, 0, 0, 0);
    expectAt(e + 11, "cfg_in_run",    ST_RUN,  2,  0, 0, 0, 0, 0);
    expectAt(e + 40, "pre_warn",      ST_RUN,  9,  0, 0, 0, 0, 0);
    expectAt(e + 41, "warn_entry",    ST_WARN, 10, 1, 0, 0, 0, 0);
    expectAt(e + 72, "pre_bite",      ST_WARN, 10, 1, 0, 0, 0, 0);
    expectAt(e + 73, "bite_entry",    ST_BITE, 10, 0, 1, 0, 0, 0);
    expectAt(e + 76, "bite_kick_ign", ST_BITE, 10, 0, 1, 0, 0, 0);
    stepTo(e + 10);
    cfg_valid = 1'b1; cfg_timeout = CNT_W'(20); cfg_window = CNT_W'(2);
    stepTo(e + 11);
    cfg_valid = 1'b0;
    stepTo(e + 75);
    kick = 1'b1;
    stepTo(e + 76);
    kick = 1'b0;
    stepTo(e + 80);
    f = cyc;
    enable = 1'b0;
    expectAt(f + 1, "bite_exit", ST_IDLE, 0, 0, 0, 0, 0, 1);
    stepTo(f + 3);

    // Kicks: legal at count 5, in WARN, on time, then early.
    g = cyc;
    enable = 1'b1;
    expectAt(g + 23, "kick_legal",   ST_RUN,  0,  0, 0, 0, 0, 0);
    expectAt(g + 27, "count_resume", ST_RUN,  1,  0, 0, 0, 0, 0);
    expectAt(g + 62, "kick_pre_warn", ST_RUN, 9,  0, 0, 0, 0, 0);
    expectAt(g + 63, "kick_warn",    ST_WARN, 10, 1, 0, 0, 0, 0);
    expectAt(g + 69, "warn_kick",    ST_RUN,  0,  0, 0, 0, 0, 0);
    expectAt(g + 87, "ontime_kick",  ST_RUN,  0,  0, 0, 0, 0, 0);
    expectAt(g + 93, "early_kick",   ST_BITE, 1,  0, 1, 1, 0, 0);
    expectAt(g + 94, "early_pulse_end", ST_BITE, 1, 0, 1, 0, 0, 0);
    stepTo(g + 22); kick = 1'b1; stepTo(g + 23); kick = 1'b0;
    stepTo(g + 68); kick = 1'b1; stepTo(g + 69); kick = 1'b0;
    stepTo(g + 86); kick = 1'b1; stepTo(g + 87); kick = 1'b0;
    stepTo(g + 92); kick = 1'b1; stepTo(g + 93); kick = 1'b0;
    stepTo(g + 96);
    enable = 1'b0;
    expectAt(g + 97, "early_exit", ST_IDLE, 0, 0, 0, 0, 0, 1);
    stepTo(g + 99);

    // Async reset mid-WARN, then run with reverted (all-ones) timeout.
    h = cyc;
    enable = 1'b1;
    expectAt(h + 41, "rst_pre_warn", ST_WARN, 10, 1, 0, 0, 0, 0);
    stepTo(h + 50);
    rst = 1'b1;
    expectAt(h + 50, "rst_mid_warn", ST_IDLE, 0, 0, 0, 0, 0, 1);
    stepTo(h + 52);
    rst = 1'b0;
    expectAt(h + 53, "post_rst_run",  ST_RUN, 0,  0, 0, 0, 0, 0);
    expectAt(h + 97, "post_rst_to_ff", ST_RUN, 11, 0, 0, 0, 0, 0);
    stepTo(h + 100);
    enable = 1'b0;
    expectAt(h + 101, "final_idle", ST_IDLE, 0, 0, 0, 0, 0, 1);
    stepTo(h + 105);

    while (sbQueue.size() > 0) begin
      cmpCount++;
      errCount++;
      $display("[TB] FAIL %s: leftover expectation for cyc %0d", sbQueue[0].name, sbQueue[0].cyc);
      sbQueue.delete(0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

endmodule
